// File: rtl/dmem_mmio_responder.sv
// Data-port responder for the core's M stage: word RAM plus an MMIO page holding a
// cycle counter, a compare timer with a sticky IRQ, and a byte TX FIFO.
module dmem_mmio_responder #(
   parameter int          RAM_WORDS  = 64,
   parameter logic [19:0] MMIO_PAGE  = 20'hFFFFF,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] DataAdrM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic          ram_hit, mmio_hit;
   logic [11:0]   off;
   logic [AW-1:0] ram_idx;
   logic          unused_addr_bits;

   assign ram_hit          = (DataAdrM[31:AW+2] == '0);
   assign mmio_hit         = (DataAdrM[31:12] == MMIO_PAGE);
   assign off              = DataAdrM[11:0];
   assign ram_idx          = DataAdrM[AW+1:2];
   assign unused_addr_bits = ^DataAdrM[1:0];

   logic [31:0]   ram_q [RAM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [31:0]   cycle_q, cycle_d;
   logic [31:0]   cmp_q, cmp_d;
   logic          pend_q, pend_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic fifo_full, fifo_empty, push, pop, push_ok;
   logic cmp_wr, status_wr, timer_hit;
   logic [31:0] status_word;

   assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty  = (count_q == '0);
   assign push        = MemWriteM & mmio_hit & (off == 12'h00C);
   assign pop         = tx_valid & tx_ready;
   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign push_ok     = push & (~fifo_full | pop);
   assign cmp_wr      = MemWriteM & mmio_hit & (off == 12'h004);
   assign status_wr   = MemWriteM & mmio_hit & (off == 12'h008);
   assign timer_hit   = (cycle_q == cmp_q);
   assign status_word = {16'h0000, 8'(count_q), 4'h0, ovf_q, fifo_empty, fifo_full, pend_q};

   assign tx_valid  = ~fifo_empty;
   assign tx_data   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
   assign timer_irq = pend_q;

   always_comb begin
      ReadDataM = '0;
      if (ram_hit) begin
         ReadDataM = ram_q[ram_idx];
      end else if (mmio_hit) begin
         case (off)
            12'h000: ReadDataM = cycle_q;
            12'h004: ReadDataM = cmp_q;
            12'h008: ReadDataM = status_word;
            default: ReadDataM = '0;
         endcase
      end
   end

   always_comb begin
      cycle_d  = cycle_q + 32'd1;
      cmp_d    = cmp_wr ? WriteDataM : cmp_q;
      // Set beats a same-cycle W1C clear for both sticky bits.
      pend_d   = timer_hit | (pend_q & ~(status_wr & WriteDataM[0]));
      ovf_d    = (push & fifo_full & ~pop) | (ovf_q & ~(status_wr & WriteDataM[3]));
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q  <= '0;
         cmp_q    <= 32'hFFFF_FFFF;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         cycle_q  <= cycle_d;
         cmp_q    <= cmp_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage arrays are not reset; RAM survives reset, FIFO slots are masked by count.
   always_ff @(posedge clk) begin
      if (!reset && MemWriteM && ram_hit) ram_q[ram_idx] <= WriteDataM;
      if (!reset && push_ok) fifo_q[wr_ptr_q] <= WriteDataM[7:0];
   end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM/decode vector table followed by
// hand-written timer, FIFO and reset sequences.
module tb_dmem_mmio_responder;
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_F000;
   localparam logic [31:0] A_CMP    = 32'hFFFF_F004;
   localparam logic [31:0] A_STATUS = 32'hFFFF_F008;
   localparam logic [31:0] A_TX     = 32'hFFFF_F00C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWriteM = 1'b0;
   logic [31:0] DataAdrM = '0;
   logic [31:0] WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        timer_irq;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   dmem_mmio_responder #(.RAM_WORDS(64), .MMIO_PAGE(20'hFFFFF), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .DataAdrM(DataAdrM),
      .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemWriteM  = 1'b1;
      DataAdrM   = a;
      WriteDataM = d;
      tick();
      MemWriteM  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      MemWriteM = 1'b0;
      DataAdrM  = a;
      #1;
      d = ReadDataM;
   endtask

   task automatic check_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic drain();
      int guard;
      logic [31:0] e;
      guard = 0;
      tx_ready = 1'b1;
      while (exp_q.size() > 0 && guard < 20) begin
         if (tx_valid) begin
            e = exp_q.pop_front();
            check("tx_data_drain", {24'h0, tx_data}, e);
         end
         tick();
         guard++;
      end
      check("drain_left", exp_q.size(), 0);
      check("tx_valid_after_drain", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] c;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          "ram_wr"};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_rd_10"};
      vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_rd_13"};
      vecs[3]  = '{1'b0, 32'h0001_0000, 32'h0,         1'b1, 32'h0,          "unmapped_rd"};
      vecs[4]  = '{1'b1, 32'h0001_0000, 32'h1234_5678, 1'b0, 32'h0,          "unmapped_wr"};
      vecs[5]  = '{1'b0, 32'h0001_0000, 32'h0,         1'b1, 32'h0,          "unmapped_rd2"};
      vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h0,          "ram_wr_top"};
      vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hA5A5_A5A5, "ram_rd_top"};
      vecs[8]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,          "ram_wr_0"};
      vecs[9]  = '{1'b1, 32'h0000_0100, 32'h2222_2222, 1'b0, 32'h0,          "alias_wr"};
      vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, "ram_no_alias"};
      vecs[11] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF, "rd_during_wr"};
      vecs[12] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D, "rd_new_data"};
      vecs[13] = '{1'b0, A_CMP,         32'h0,         1'b1, 32'hFFFF_FFFF, "cmp_reset"};
      vecs[14] = '{1'b0, 32'hFFFF_F010, 32'h0,         1'b1, 32'h0,          "mmio_unused"};
      vecs[15] = '{1'b0, 32'hFFFF_E004, 32'h0,         1'b1, 32'h0,          "other_page"};

      repeat (2) tick();
      reset = 1'b0;
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_irq", {31'h0, timer_irq}, 32'h0);
      check_rd("rst_status", A_STATUS, 32'h0000_0004);

      // Table: inputs applied, combinational read checked before the edge.
      for (int i = 0; i < 16; i++) begin
         MemWriteM  = vecs[i].we;
         DataAdrM   = vecs[i].addr;
         WriteDataM = vecs[i].wdata;
         #1;
         if (vecs[i].chk) check(vecs[i].name, ReadDataM, vecs[i].exp);
         tick();
      end
      MemWriteM = 1'b0;

      // Cycle counter and compare timer.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      check_rd("cycle_5", A_CYCLE, 32'd5);
      wr(A_CMP, 32'd20);
      check("irq_early", {31'h0, timer_irq}, 32'h0);
      check_rd("cmp_rd", A_CMP, 32'd20);
      repeat (14) tick();
      check("irq_at_match", {31'h0, timer_irq}, 32'h0);
      check_rd("cycle_20", A_CYCLE, 32'd20);
      tick();
      check("irq_rise", {31'h0, timer_irq}, 32'h1);
      tick();
      check("irq_sticky", {31'h0, timer_irq}, 32'h1);
      check_rd("status_pend", A_STATUS, 32'h0000_0005);
      wr(A_STATUS, 32'h1);
      check("irq_cleared", {31'h0, timer_irq}, 32'h0);
      check_rd("status_clr", A_STATUS, 32'h0000_0004);

      // Clear lands on the same edge as a match: set must win.
      rd(A_CYCLE, c);
      wr(A_CMP, c + 32'd3);
      tick();
      tick();
      wr(A_STATUS, 32'h1);
      check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
      wr(A_STATUS, 32'h1);
      check("irq_clr2", {31'h0, timer_irq}, 32'h0);

      // Overflow on the fifth push with the consumer stalled.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr(A_TX, 32'h41 + i);
         if (i < 4) exp_q.push_back(32'h41 + i);
         if (i == 0) begin
            check("tx_valid_first", {31'h0, tx_valid}, 32'h1);
            check("tx_data_first", {24'h0, tx_data}, 32'h41);
         end
      end
      check_rd("status_full_ovf", A_STATUS, 32'h0000_040A);
      drain();
      wr(A_STATUS, 32'h8);
      check_rd("status_ovf_clr", A_STATUS, 32'h0000_0004);

      // Push into a full FIFO while the head pops.
      for (int i = 0; i < 4; i++) begin
         wr(A_TX, 32'h51 + i);
         exp_q.push_back(32'h51 + i);
      end
      check("tx_head_51", {24'h0, tx_data}, 32'h51);
      tx_ready = 1'b1;
      wr(A_TX, 32'h99);
      tx_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(32'h99);
      check_rd("status_full_pushpop", A_STATUS, 32'h0000_0402);
      check("tx_head_52", {24'h0, tx_data}, 32'h52);
      drain();

      // Reset mid-drain with the timer pending and a concurrent push.
      for (int i = 0; i < 3; i++) wr(A_TX, 32'h61 + i);
      rd(A_CYCLE, c);
      wr(A_CMP, c + 32'd2);
      tick();
      tick();
      check("irq_before_reset", {31'h0, timer_irq}, 32'h1);
      reset      = 1'b1;
      MemWriteM  = 1'b1;
      DataAdrM   = A_TX;
      WriteDataM = 32'h77;
      tick();
      MemWriteM  = 1'b0;
      reset      = 1'b0;
      exp_q.delete();
      check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst2_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst2_irq", {31'h0, timer_irq}, 32'h0);
      check_rd("rst2_cycle", A_CYCLE, 32'h0);
      tick();
      check_rd("rst2_ram", 32'h0000_0010, 32'hDEAD_BEEF);
      check_rd("rst2_status", A_STATUS, 32'h0000_0004);
      check_rd("rst2_cmp", A_CMP, 32'hFFFF_FFFF);

      // Loads are side-effect free; CYCLE ignores stores.
      wr(A_TX, 32'h7E);
      exp_q.push_back(32'h7E);
      check_rd("txdata_rd", A_TX, 32'h0);
      check_rd("offset_010_rd", 32'hFFFF_F010, 32'h0);
      check_rd("status_count1", A_STATUS, 32'h0000_0100);
      tick();
      rd(A_CYCLE, c);
      wr(A_CYCLE, 32'h0);
      check_rd("cycle_ignores_wr", A_CYCLE, c + 32'd1);
      check_rd("status_count1b", A_STATUS, 32'h0000_0100);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
